// File: rtl/wisc_pkg.sv
// Shared opcode map, controller state encoding and branch-condition codes
// for the WISC multicycle control unit.
package wisc_pkg;

    // Opcode map
    localparam logic [3:0] OPC_ADD    = 4'h0;
    localparam logic [3:0] OPC_SUB    = 4'h1;
    localparam logic [3:0] OPC_XOR    = 4'h2;
    localparam logic [3:0] OPC_RED    = 4'h3;
    localparam logic [3:0] OPC_SLL    = 4'h4;
    localparam logic [3:0] OPC_SRA    = 4'h5;
    localparam logic [3:0] OPC_ROR    = 4'h6;
    localparam logic [3:0] OPC_PADDSB = 4'h7;
    localparam logic [3:0] OPC_LW     = 4'h8;
    localparam logic [3:0] OPC_SW     = 4'h9;
    localparam logic [3:0] OPC_LLB    = 4'hA;
    localparam logic [3:0] OPC_LHB    = 4'hB;
    localparam logic [3:0] OPC_B      = 4'hC;
    localparam logic [3:0] OPC_BR     = 4'hD;
    localparam logic [3:0] OPC_PCS    = 4'hE;
    localparam logic [3:0] OPC_HLT    = 4'hF;

    // Branch condition codes (flags are {Z,V,N})
    localparam logic [2:0] CCC_NE  = 3'b000;
    localparam logic [2:0] CCC_EQ  = 3'b001;
    localparam logic [2:0] CCC_GT  = 3'b010;
    localparam logic [2:0] CCC_LT  = 3'b011;
    localparam logic [2:0] CCC_GE  = 3'b100;
    localparam logic [2:0] CCC_LE  = 3'b101;
    localparam logic [2:0] CCC_OVF = 3'b110;
    localparam logic [2:0] CCC_UNC = 3'b111;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        ERR
    } state_t;

    // Instructions whose ALU B operand is the immediate field
    function automatic logic uses_imm(input logic [3:0] op);
        return op inside {OPC_SLL, OPC_SRA, OPC_ROR, OPC_LW, OPC_SW, OPC_LLB, OPC_LHB};
    endfunction

    // Instructions that update the flag register
    function automatic logic sets_flags(input logic [3:0] op);
        return op inside {OPC_ADD, OPC_SUB, OPC_XOR, OPC_SLL, OPC_SRA, OPC_ROR};
    endfunction

endpackage

// File: rtl/mc_control_br_cond.sv
// Branch-condition evaluator: decides whether a conditional branch is taken
// from the condition field and the current {Z,V,N} flags.
module br_cond
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z, v, n;

    assign z = flags[2];
    assign v = flags[1];
    assign n = flags[0];

    // Condition decode
    always_comb begin
        taken = 1'b0;
        case (ccc)
            CCC_NE:  taken = ~z;
            CCC_EQ:  taken = z;
            CCC_GT:  taken = ~z & ~n;
            CCC_LT:  taken = n;
            CCC_GE:  taken = z | ~n;
            CCC_LE:  taken = n | z;
            CCC_OVF: taken = v;
            CCC_UNC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM for the WISC processor: sequences fetch, decode,
// execute, memory and writeback, with a bounded wait on each memory
// handshake that falls into a sticky error state on timeout.
module mc_control
    import wisc_pkg::*;
#(
    parameter int MEM_TO_CYC = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_load,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       reg_write,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       lxb,
    output logic       pcs_sel,
    output logic       flag_we,
    output logic       pc_load,
    output logic       br_taken,
    output logic       halted,
    output logic       err
);

    // Counter value at which one more waiting cycle means timeout
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TO_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       opc_q, opc_d;
    logic             taken;

    br_cond u_br_cond (
        .ccc   (ccc),
        .flags (flags),
        .taken (taken)
    );

    // State, wait counter and latched opcode registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
        end
    end

    // Next-state, wait-counter and control-output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        opc_d      = opc_q;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        lxb        = 1'b0;
        pcs_sel    = 1'b0;
        flag_we    = 1'b0;
        pc_load    = 1'b0;
        br_taken   = 1'b0;
        halted     = 1'b0;
        err        = 1'b0;

        case (state_q)
            FETCH: begin
                // Reset holds the FSM in FETCH, so the fetch strobes are
                // gated by rst_n to keep every output low during reset.
                imem_req = rst_n;
                if (imem_ready) begin
                    ir_load = rst_n;
                    state_d = DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DECODE: begin
                opc_d   = opcode;
                state_d = (opcode == OPC_HLT) ? HALT : EXEC;
            end

            EXEC: begin
                alu_src = uses_imm(opc_q);
                case (opc_q)
                    OPC_LW, OPC_SW: state_d = MEM;
                    OPC_B, OPC_BR: begin
                        pc_load  = 1'b1;
                        br_taken = taken;
                        state_d  = FETCH;
                    end
                    default: begin
                        flag_we = sets_flags(opc_q);
                        state_d = WB;
                    end
                endcase
            end

            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opc_q == OPC_SW);
                alu_src  = uses_imm(opc_q);
                if (dmem_ready) begin
                    if (opc_q == OPC_SW) begin
                        pc_load = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WB: begin
                reg_write  = 1'b1;
                pc_load    = 1'b1;
                alu_src    = uses_imm(opc_q);
                mem_to_reg = (opc_q == OPC_LW);
                lxb        = (opc_q == OPC_LLB) || (opc_q == OPC_LHB);
                pcs_sel    = (opc_q == OPC_PCS);
                state_d    = FETCH;
            end

            HALT: halted = 1'b1;

            ERR: err = 1'b1;

            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-instruction expected output traces
// are built from the instruction-level rules and compared every cycle.
module tb_mc_control;

    localparam int TO = 15;

    // Bit positions in the observed/expected output vector
    localparam int B_IMEM = 13;
    localparam int B_IRL  = 12;
    localparam int B_DREQ = 11;
    localparam int B_DWE  = 10;
    localparam int B_RW   = 9;
    localparam int B_ALU  = 8;
    localparam int B_M2R  = 7;
    localparam int B_LXB  = 6;
    localparam int B_PCS  = 5;
    localparam int B_FWE  = 4;
    localparam int B_PCL  = 3;
    localparam int B_BRT  = 2;
    localparam int B_HLT  = 1;
    localparam int B_ERR  = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = '0;
    logic [2:0] ccc = '0;
    logic [2:0] flags = '0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, ir_load, dmem_req, dmem_we, reg_write, alu_src;
    logic       mem_to_reg, lxb, pcs_sel, flag_we, pc_load, br_taken, halted, err;
    logic [13:0] obs;

    int checks = 0;
    int failures = 0;

    mc_control #(
        .MEM_TO_CYC (TO),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .ccc        (ccc),
        .flags      (flags),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_load    (ir_load),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .lxb        (lxb),
        .pcs_sel    (pcs_sel),
        .flag_we    (flag_we),
        .pc_load    (pc_load),
        .br_taken   (br_taken),
        .halted     (halted),
        .err        (err)
    );

    assign obs = {imem_req, ir_load, dmem_req, dmem_we, reg_write, alu_src,
                  mem_to_reg, lxb, pcs_sel, flag_we, pc_load, br_taken, halted, err};

    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit imm_op(input logic [3:0] op);
        return op inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    function automatic bit flag_op(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6};
    endfunction

    function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    // Irrelevant inputs get fresh random values every cycle
    task automatic noise();
        opcode = 4'($urandom);
        ccc    = 3'($urandom);
        flags  = 3'($urandom);
    endtask

    // Inputs are already driven (posedge+1); sample at negedge, then advance
    task automatic cyc(input string tag, input logic [13:0] exp);
        @(negedge clk);
        check_out(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        noise();
        #1;
        check_out("reset_async", obs, '0);
        @(negedge clk);
        check_out("reset_hold", obs, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic err_tail();
        logic [13:0] e;
        for (int k = 0; k < 4; k++) begin
            noise();
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            e = '0;
            e[B_ERR] = 1'b1;
            cyc("err", e);
        end
    endtask

    // One instruction: idly/ddly are waiting cycles before ready (>= TO means
    // never ready), cc_in/fl_in force branch inputs (-1 = random), abort_mem
    // asserts reset before that MEM cycle (-1 = never).
    task automatic run_instr(input logic [3:0] op, input int idly, input int ddly,
                             input int cc_in, input int fl_in, input int abort_mem,
                             output bit dead);
        logic [13:0] e;
        dead = 1'b0;

        for (int i = 0; i < TO; i++) begin
            noise();
            dmem_ready = 1'($urandom_range(0, 1));
            imem_ready = (i == idly);
            e = '0;
            e[B_IMEM] = 1'b1;
            e[B_IRL]  = imem_ready;
            cyc("fetch", e);
            if (i == idly) break;
        end
        if (idly >= TO) begin
            err_tail();
            dead = 1'b1;
            return;
        end

        noise();
        opcode = op;
        imem_ready = 1'($urandom_range(0, 1));
        dmem_ready = 1'($urandom_range(0, 1));
        cyc("decode", '0);

        if (op == 4'hF) begin
            for (int k = 0; k < 4; k++) begin
                noise();
                imem_ready = 1'b1;
                dmem_ready = 1'b1;
                e = '0;
                e[B_HLT] = 1'b1;
                cyc("halt", e);
            end
            dead = 1'b1;
            return;
        end

        noise();
        if (cc_in >= 0) ccc = 3'(cc_in);
        if (fl_in >= 0) flags = 3'(fl_in);
        imem_ready = 1'($urandom_range(0, 1));
        dmem_ready = 1'($urandom_range(0, 1));
        e = '0;
        e[B_ALU] = imm_op(op);
        if (op == 4'hC || op == 4'hD) begin
            e[B_PCL] = 1'b1;
            e[B_BRT] = cond_ok(ccc, flags);
        end else if (op != 4'h8 && op != 4'h9) begin
            e[B_FWE] = flag_op(op);
        end
        cyc("exec", e);
        if (op == 4'hC || op == 4'hD) return;

        if (op == 4'h8 || op == 4'h9) begin
            for (int j = 0; j < TO; j++) begin
                if (j == abort_mem) begin
                    do_reset();
                    dead = 1'b1;
                    return;
                end
                noise();
                imem_ready = 1'($urandom_range(0, 1));
                dmem_ready = (j == ddly);
                e = '0;
                e[B_DREQ] = 1'b1;
                e[B_DWE]  = (op == 4'h9);
                e[B_ALU]  = 1'b1;
                e[B_PCL]  = (op == 4'h9) && dmem_ready;
                cyc("mem", e);
                if (j == ddly) break;
            end
            if (ddly >= TO) begin
                err_tail();
                dead = 1'b1;
                return;
            end
            if (op == 4'h9) return;
        end

        noise();
        imem_ready = 1'($urandom_range(0, 1));
        dmem_ready = 1'($urandom_range(0, 1));
        e = '0;
        e[B_RW]  = 1'b1;
        e[B_PCL] = 1'b1;
        e[B_ALU] = imm_op(op);
        e[B_M2R] = (op == 4'h8);
        e[B_LXB] = (op == 4'hA) || (op == 4'hB);
        e[B_PCS] = (op == 4'hE);
        cyc("wb", e);
    endtask

    task automatic run_and_recover(input logic [3:0] op, input int idly, input int ddly,
                                   input int cc_in, input int fl_in, input int abort_mem);
        bit dead;
        run_instr(op, idly, ddly, cc_in, fl_in, abort_mem, dead);
        if (dead) do_reset();
    endtask

    function automatic int rand_delay();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(5, 14));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // ADD with fetch ready on the third cycle
        run_and_recover(4'h0, 2, 0, -1, -1, -1);
        // LW / SW with data ready after a few cycles
        run_and_recover(4'h8, 0, 3, -1, -1, -1);
        run_and_recover(4'h9, 1, 2, -1, -1, -1);
        // B with ccc=001, Z set and clear
        run_and_recover(4'hC, 0, 0, 1, 3'b100, -1);
        run_and_recover(4'hC, 0, 0, 1, 3'b011, -1);
        // ccc=111 taken for every flag pattern
        for (int f = 0; f < 8; f++) run_and_recover(4'hD, 0, 0, 7, f, -1);
        // Data timeout, then ready on the last allowed cycle
        run_and_recover(4'h8, 0, TO, -1, -1, -1);
        run_and_recover(4'h8, 0, TO - 1, -1, -1, -1);
        run_and_recover(4'h9, 0, TO - 1, -1, -1, -1);
        // Fetch timeout and fetch ready on the last allowed cycle
        run_and_recover(4'h2, TO, 0, -1, -1, -1);
        run_and_recover(4'hE, TO - 1, 0, -1, -1, -1);
        // HLT
        run_and_recover(4'hF, 1, 0, -1, -1, -1);
        // Reset in the middle of a data handshake
        run_and_recover(4'h8, 1, 10, -1, -1, 3);
        run_and_recover(4'hA, 0, 0, -1, -1, -1);

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
            run_and_recover(op, rand_delay(), rand_delay(), -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL take parameter MEM_TO_CYC, default 15: maximum wait cycles for any memory handshake before the error state.
REQ-002 The block SHALL take parameter CNT_W, default 4: wait-counter width, with CNT_W >= clog2(MEM_TO_CYC+1).
REQ-003 The block SHALL have these ports, clock and reset first:
- clk  in  1  -- single clock; all state updates on its rising edge.
- rst_n  in  1  -- asynchronous, active-low reset.
- opcode  in  4  -- instruction-register opcode field; valid from the DECODE cycle onward.
- ccc  in  3  -- branch condition field.
- flags  in  3  -- {Z,V,N}.
- imem_ready  in  1  -- instruction fetch complete.
- dmem_ready  in  1  -- data access complete.
- imem_req  out  1  -- instruction fetch request.
- ir_load  out  1  -- load instruction register.
- dmem_req  out  1  -- data access request.
- dmem_we  out  1  -- data access is a write.
- reg_write  out  1  -- register file write enable.
- alu_src  out  1  -- ALU B operand is the immediate.
- mem_to_reg  out  1  -- writeback data comes from memory.
- lxb  out  1  -- LLB/LHB writeback path.
- pcs_sel  out  1  -- writeback data is PC+2.
- flag_we  out  1  -- flag register write enable.
- pc_load  out  1  -- update PC.
- br_taken  out  1  -- PC source is the branch target.
- halted  out  1  -- processor halted.
- err  out  1  -- memory timeout occurred.

Function
REQ-004 The opcode map SHALL be: 0-7 compute (ADD,SUB,XOR,RED,SLL,SRA,ROR,PADDSB); 8 LW; 9 SW; A LLB; B LHB; C B; D BR; E PCS; F HLT.
REQ-005 The FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT and ERR.
REQ-006 FETCH SHALL assert imem_req continuously until imem_ready=1; in that cycle it SHALL pulse ir_load and go to DECODE.
REQ-007 DECODE SHALL last 1 cycle, latch opcode internally, and go to HALT on opcode F and to EXEC otherwise.
REQ-008 EXEC SHALL go to MEM on LW or SW, and to FETCH on B or BR with pc_load=1 and br_taken=cond.
REQ-009 EXEC SHALL go to WB for all other opcodes, with flag_we=1 only for ADD, SUB, XOR, SLL, SRA and ROR.
REQ-010 MEM SHALL hold dmem_req=1, with dmem_we=1 for SW, until dmem_ready=1.
REQ-011 When dmem_ready=1 in MEM, LW SHALL go to WB and SW SHALL go to FETCH with pc_load=1.
REQ-012 WB SHALL assert reg_write=1 and pc_load=1 for one cycle and then go to FETCH.
REQ-013 In WB, mem_to_reg SHALL be 1 for LW, lxb SHALL be 1 for opcodes A and B, and pcs_sel SHALL be 1 for opcode E.
REQ-014 alu_src SHALL be 1 in EXEC, MEM and WB for opcodes 4, 5, 6, 8, 9, A and B.
REQ-015 Branch condition SHALL decode as: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|N=0; 101 N=1|Z=1; 110 V=1; 111 always taken.
REQ-016 Opcode C SHALL use the immediate target, opcode D the register target; both SHALL use the REQ-015 condition and neither SHALL write a register.
REQ-017 The wait counter SHALL clear on entering FETCH or MEM and increment once per waiting cycle.
REQ-018 If the wait counter reaches MEM_TO_CYC without ready, the FSM SHALL go to ERR.
REQ-019 A ready in the same cycle the counter reaches the limit SHALL win, and the normal transition SHALL be taken.
REQ-020 ERR and HALT SHALL be terminal until reset; in them all request and enable outputs SHALL be 0.
REQ-021 halted SHALL be 1 in HALT; err SHALL be 1 in ERR and stay 1 (sticky).
REQ-022 Outputs SHALL be combinational from registered state, latched opcode and the live ready, ccc and flags inputs only; there SHALL be no combinational path from opcode to outputs outside DECODE.
REQ-023 A ready input asserted outside its matching wait state SHALL be ignored.

Reset
REQ-024 rst_n=0 SHALL immediately force state FETCH, wait counter 0 and latched opcode 0.
REQ-025 Every output SHALL be 0 while rst_n=0, including imem_req, which is gated by reset.
REQ-026 The first cycle after reset release SHALL assert imem_req=1.
REQ-027 Reset asserted mid-handshake SHALL abort that handshake with no further outputs asserted.

Structure
REQ-028 Opcode localparams, the state enum and the ccc encodings SHALL live in a shared package, wisc_pkg.
REQ-029 Branch-condition evaluation SHALL be one sub-module, br_cond, with inputs ccc and flags and output taken.

Verification
REQ-030 ADD with imem_ready after 2 cycles: imem_req is high 3 cycles, then DECODE, EXEC (flag_we=1), WB (reg_write=1, pc_load=1), FETCH; 6 cycles total.
REQ-031 LW with dmem_ready after 3 cycles: dmem_req held 4 cycles with dmem_we=0, then WB with mem_to_reg=1; SW completes with pc_load=1 and reg_write never 1.
REQ-032 B with ccc=001: Z=1 gives br_taken=1 and pc_load=1; Z=0 gives br_taken=0 and pc_load=1; ccc=111 is taken for all flags.
REQ-033 dmem_ready held low 15 cycles: ERR entered and err=1 sticky; a separate run with ready on exactly cycle 15 completes normally.
REQ-034 HLT: halted=1 and no imem_req afterwards; rst_n pulsed low mid-MEM: outputs 0 at once, and imem_req=1 on the first cycle after release.
